// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream and writes it into
// instruction memory. Each instruction is assembled as a little-endian 32-bit
// word. The CPU is held in reset until the whole image is written and its
// checksum matches.
//
// Stream format: 4-byte LE word count N, then N words of 4 LE bytes each,
// then one checksum byte. The checksum is the XOR of the payload bytes only.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         begins a load (honoured in IDLE, DONE and ERR)
//   byte_in       stream byte
//   byte_valid    byte_in holds a valid byte
//   byte_ready    loader accepts a byte this cycle
//   we_out        one-cycle write strobe per assembled word
//   wa_out        instruction-memory byte address of the write
//   wd_out        instruction word being written
//   cpu_hold      keeps the CPU core in reset while high
//   done          image loaded and checksum matched
//   error         oversize image or checksum mismatch
//   words_loaded  number of words written in the current load
module imem_loader #(
  parameter int unsigned                 DATA_WIDTH = 32,
  parameter int unsigned                 ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       BASE_ADDR  = 32'hBFC00000,
  parameter int unsigned                 MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  we_out,
  output logic [ADDR_WIDTH-1:0] wa_out,
  output logic [DATA_WIDTH-1:0] wd_out,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q;
  logic [1:0]              idx_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [15:0]             n_q;
  logic [7:0]              csum_q;
  logic                    byte_ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   wa_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic                    cpu_hold_q;
  logic                    done_q;
  logic                    error_q;
  logic [15:0]             words_q;

  logic                    accept;
  logic                    last_byte;
  logic                    last_word;
  logic [DATA_WIDTH-1:0]   word_d;
  logic [7:0]              csum_d;
  logic [ADDR_WIDTH-1:0]   wa_d;

  assign accept    = byte_valid && byte_ready_q;
  assign last_byte = (idx_q == 2'd3);
  // New bytes enter at the top and shift down, so after four bytes the first
  // byte received sits in bits [7:0]. The header count uses the same register.
  assign word_d    = {byte_in, word_q[DATA_WIDTH-1:8]};
  assign csum_d    = csum_q ^ byte_in;
  assign wa_d      = BASE_ADDR + ADDR_WIDTH'({words_q, 2'b00});
  assign last_word = ((words_q + 16'd1) == n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      n_q          <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= BASE_ADDR;
      wd_q         <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_HDR;
            byte_ready_q <= 1'b1;
            idx_q        <= '0;
            words_q      <= '0;
            csum_q       <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
          end
        end
        S_HDR: begin
          if (accept) begin
            word_q <= word_d;
            idx_q  <= idx_q + 2'd1;
            if (last_byte) begin
              if (word_d > DATA_WIDTH'(MAX_WORDS)) begin
                state_q      <= S_ERR;
                error_q      <= 1'b1;
                byte_ready_q <= 1'b0;
              end else if (word_d == '0) begin
                state_q <= S_CSUM;
              end else begin
                // Count already bounded by MAX_WORDS, which fits in 16 bits.
                n_q     <= word_d[15:0];
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_q <= word_d;
            csum_q <= csum_d;
            idx_q  <= idx_q + 2'd1;
            if (last_byte) begin
              we_q    <= 1'b1;
              wa_q    <= wa_d;
              wd_q    <= word_d;
              words_q <= words_q + 16'd1;
              if (last_word) state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            byte_ready_q <= 1'b0;
            if (byte_in == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready   = byte_ready_q;
  assign we_out       = we_q;
  assign wa_out       = wa_q;
  assign wd_out       = wd_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory read path used by the fetch/decode stage. It receives a program image as a byte stream, assembles little-endian 32-bit instructions and writes them sequentially into the instruction memory's write port.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image has been written, then releases it so fetch starts from BASE_ADDR.

Parameters:
- DATA_WIDTH, 32, instruction/word width (fixed at 32; the byte assembly assumes 4 bytes per word).
- ADDR_WIDTH, 32, width of the write address.
- BASE_ADDR, 32'hBFC00000, byte address of the first instruction written.
- MAX_WORDS, 1024, largest accepted image size, in words.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- we_out  output  1  instruction-memory write enable; one-cycle pulse per word.
- wa_out  output  ADDR_WIDTH  instruction-memory byte address.
- wd_out  output  DATA_WIDTH  instruction word to write.
- cpu_hold  output  1  holds the CPU core in reset while high.
- done  output  1  image loaded and checksum matched.
- error  output  1  oversize image or checksum mismatch.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values (asynchronous on rst): state=IDLE, byte_ready=0, we_out=0, wa_out=BASE_ADDR, wd_out=0, cpu_hold=1, done=0, error=0, words_loaded=0, checksum accumulator=0, byte index=0.
- Stream format: 4-byte little-endian word count N, then N words as 4 little-endian bytes each, then 1 checksum byte. The checksum is the XOR of all payload bytes only; header bytes are excluded.
- A byte is accepted when byte_valid && byte_ready. byte_ready is high in HDR, DATA and CSUM, and low in every other state. The write port never stalls, so byte_ready does not drop during writes.
- States:
  - IDLE: wait for start.
  - On start (from IDLE, DONE or ERR): go to HDR. Clear words_loaded, the accumulator, done and error. Set cpu_hold=1.
  - HDR: assemble N from 4 accepted bytes. On the 4th byte:
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA:
    - Every accepted byte is XORed into the accumulator and shifted into the word in little-endian order; byte k lands in bits [8k+7:8k].
    - On the 4th byte of word i, the next cycle shows we_out=1, wa_out=BASE_ADDR+4*i and wd_out=the assembled word.
    - words_loaded increments in that same cycle.
    - After word N-1, go to CSUM.
  - CSUM: one accepted byte.
    - Byte equals accumulator: go to DONE, set done=1 and cpu_hold=0 on the same edge.
    - Otherwise: go to ERR, set error=1, keep cpu_hold=1.
  - DONE, ERR: hold their outputs until start or rst.
- we_out is high for exactly one cycle per word. wa_out and wd_out keep their last written values between pulses.
- start while in HDR, DATA or CSUM is ignored and the load continues.
- A byte accepted in the same cycle as a word-completing write is legal. Back-to-back bytes every cycle must be sustained, giving a worst-case we_out spacing of 4 cycles.
- rst mid-load aborts the load immediately and returns all outputs to their reset values. Words already written to memory are not cleared.
- words_loaded is a 16-bit counter and never wraps, because MAX_WORDS < 2^16 is a legal-parameter requirement.

Test Plan:
- Nominal load: start, N=2 (bytes 02 00 00 00), payload 93 00 50 00 13 01 A0 00, checksum 71.
  - Required: we_out pulses with (0xBFC00000, 0x00500093) then (0xBFC00004, 0x00A00113).
  - Then done=1, cpu_hold=0, words_loaded=2, error=0.
- Bad checksum: same stream with checksum 70 -> error=1, done=0, cpu_hold=1; both writes still occur.
- Oversize: header for N=1025 (01 04 00 00) -> ERR after the 4th header byte, with no we_out pulses and byte_ready=0.
- Empty image: N=0 followed by checksum 00 -> DONE with no writes and cpu_hold=0. Checksum 01 instead -> ERR.
- Flow control and restart:
  - byte_valid toggles randomly through a nominal load -> identical writes.
  - start pulsed mid-DATA is ignored.
  - start in DONE -> cpu_hold=1, done=0, and a reload succeeds.
- Reset mid-load: assert rst after 5 payload bytes -> all outputs at reset values immediately (asynchronously).
  - A subsequent start plus a full stream completes normally from BASE_ADDR.
